// File: rtl/pulse_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_capture
//  Purpose  : Measures the high time and the period of a pulse train. The
//             input is given as qualified single-cycle rising/falling edge
//             strobes. A free-running cycle counter is sampled on each edge.
//             Each full pulse (rise, fall, rise) yields one
//             {high_time, period} result, which is held until acknowledged.
//  Ports    : clk        - system clock, rising edge
//             nrst       - asynchronous active-low reset
//             en         - capture enable; low forces IDLE and clears the counter
//             pos_edge   - rising-edge strobe of the measured signal
//             neg_edge   - falling-edge strobe of the measured signal
//             rd_ack     - consumer acknowledge of the held result
//             high_time  - cycles from rising edge to falling edge
//             period     - cycles from rising edge to next rising edge
//             cap_valid  - unacknowledged result held
//             lost       - sticky: an unacknowledged result was overwritten
//             err        - sticky: illegal edge sequence observed
//             stall      - counter saturated, input considered stuck
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             pos_edge,
    input  logic             neg_edge,
    input  logic             rd_ack,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             cap_valid,
    output logic             lost,
    output logic             err,
    output logic             stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_high_lat;
    logic [CNT_W-1:0] w_high_lat_nxt;

    logic w_both;
    logic w_pos;
    logic w_neg;
    logic w_sat;
    logic w_accept;
    logic w_capture;
    logic w_err_set;
    logic w_stall_set;
    logic w_flag_clr;

    // Coincident strobes are an error on their own and are never treated as
    // a valid rise or fall.
    assign w_both = pos_edge & neg_edge;
    assign w_pos  = pos_edge & ~neg_edge;
    assign w_neg  = neg_edge & ~pos_edge;

    // Saturation takes priority over any edge seen in the same cycle: the
    // input is declared stuck and the measurement is abandoned.
    assign w_sat  = (r_state != IDLE) && (r_cnt == c_CNT_MAX);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_high_lat_nxt = r_high_lat;
        w_accept       = 1'b0;
        w_capture      = 1'b0;
        w_err_set      = 1'b0;
        w_stall_set    = 1'b0;

        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (w_sat) begin
            w_state_nxt = IDLE;
            w_stall_set = 1'b1;
        end else begin
            if (r_state != IDLE) begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end

            if (w_both) begin
                w_err_set = 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_pos) begin
                            w_accept    = 1'b1;
                            w_state_nxt = HIGH;
                        end
                    end
                    HIGH: begin
                        if (w_pos) begin
                            // Rise while already high: restart, no result.
                            w_accept  = 1'b1;
                            w_err_set = 1'b1;
                        end else if (w_neg) begin
                            w_high_lat_nxt = r_cnt;
                            w_state_nxt    = LOW;
                        end
                    end
                    LOW: begin
                        if (w_pos) begin
                            w_accept    = 1'b1;
                            w_capture   = 1'b1;
                            w_state_nxt = HIGH;
                        end else if (w_neg) begin
                            w_err_set = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end

            if (w_accept) begin
                w_cnt_nxt = c_CNT_ONE;
            end
        end
    end

    // Sticky flags clear only on an acknowledge that does not coincide with
    // a new capture, so a freshly delivered result keeps its history.
    assign w_flag_clr = en & rd_ack & ~w_capture;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_high_lat <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_high_lat <= w_high_lat_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            high_time <= '0;
            period    <= '0;
            cap_valid <= 1'b0;
            lost      <= 1'b0;
            err       <= 1'b0;
            stall     <= 1'b0;
        end else begin
            if (w_capture) begin
                period    <= r_cnt;
                high_time <= r_high_lat;
            end

            if (w_capture) begin
                cap_valid <= 1'b1;
            end else if (en && rd_ack) begin
                cap_valid <= 1'b0;
            end

            if (w_capture && cap_valid && !rd_ack) begin
                lost <= 1'b1;
            end else if (w_flag_clr) begin
                lost <= 1'b0;
            end

            if (w_err_set) begin
                err <= 1'b1;
            end else if (w_flag_clr) begin
                err <= 1'b0;
            end

            if (w_stall_set) begin
                stall <= 1'b1;
            end else if (w_accept) begin
                stall <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_capture
//  Purpose  : Self-checking bench for pulse_capture. A 16-bit instance takes
//             the capture scenarios; a 4-bit instance on the same stimulus
//             takes the saturation scenario. Expected captures are queued
//             when the closing rising edge is driven and popped afterwards.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_capture;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic        pos_edge;
    logic        neg_edge;
    logic        rd_ack;

    logic [15:0] high_time;
    logic [15:0] period;
    logic        cap_valid;
    logic        lost;
    logic        err;
    logic        stall;

    logic [3:0]  high_time4;
    logic [3:0]  period4;
    logic        cap_valid4;
    logic        lost4;
    logic        err4;
    logic        stall4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] ht;
        logic [15:0] per;
    } cap_t;

    cap_t exp_q[$];

    always #5 clk = ~clk;

    pulse_capture #(.CNT_W(16)) u_dut16 (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .pos_edge  (pos_edge),
        .neg_edge  (neg_edge),
        .rd_ack    (rd_ack),
        .high_time (high_time),
        .period    (period),
        .cap_valid (cap_valid),
        .lost      (lost),
        .err       (err),
        .stall     (stall)
    );

    pulse_capture #(.CNT_W(4)) u_dut4 (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .pos_edge  (pos_edge),
        .neg_edge  (neg_edge),
        .rd_ack    (rd_ack),
        .high_time (high_time4),
        .period    (period4),
        .cap_valid (cap_valid4),
        .lost      (lost4),
        .err       (err4),
        .stall     (stall4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock cycle with the given strobes; outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step(input logic p, input logic n, input logic a);
        pos_edge = p;
        neg_edge = n;
        rd_ack   = a;
        @(posedge clk);
        #1;
        pos_edge = 1'b0;
        neg_edge = 1'b0;
        rd_ack   = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input int h, input int p);
        cap_t e;
        e.ht  = 16'(h);
        e.per = 16'(p);
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        cap_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_queue: no expected entry, got ht=%0d per=%0d", tag, high_time, period);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_ht"},  32'(high_time), 32'(e.ht));
            check({tag, "_per"}, 32'(period),    32'(e.per));
            check({tag, "_cv"},  32'(cap_valid), 32'd1);
        end
    endtask

    // Starts one cycle after an accepted rising edge: fall after h cycles,
    // next rise after p cycles, and checks the resulting capture.
    task automatic run_period(input string tag, input int h, input int p,
                              input logic ack_first, input logic ack_last);
        step(1'b0, 1'b0, ack_first);
        if (ack_first) begin
            check({tag, "_ack_cv"},   32'(cap_valid), 32'd0);
            check({tag, "_ack_lost"}, 32'(lost),      32'd0);
        end
        idle(h - 2);
        step(1'b0, 1'b1, 1'b0);
        idle(p - h - 1);
        push_exp(h, p);
        step(1'b1, 1'b0, ack_last);
        pop_chk(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ht"},    32'(high_time), 32'd0);
        check({tag, "_per"},   32'(period),    32'd0);
        check({tag, "_cv"},    32'(cap_valid), 32'd0);
        check({tag, "_lost"},  32'(lost),      32'd0);
        check({tag, "_err"},   32'(err),       32'd0);
        check({tag, "_stall"}, 32'(stall),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nrst     = 1'b0;
        en       = 1'b1;
        pos_edge = 1'b0;
        neg_edge = 1'b0;
        rd_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        nrst = 1'b1;
        idle(2);

        // Basic capture; the first rise after reset gives no result.
        step(1'b1, 1'b0, 1'b0);
        check("first_pos_no_cap", 32'(cap_valid), 32'd0);
        run_period("basic", 3, 10, 1'b0, 1'b0);
        check("basic_lost", 32'(lost), 32'd0);
        check("basic_err",  32'(err),  32'd0);

        // Acknowledge, then two captures without acknowledge.
        run_period("ack", 5, 12, 1'b1, 1'b0);
        check("cap2_lost", 32'(lost), 32'd0);
        run_period("ovw", 2, 6, 1'b0, 1'b0);
        check("ovw_lost", 32'(lost), 32'd1);

        // Capture coinciding with acknowledge keeps the new result valid.
        run_period("clr", 3, 8, 1'b1, 1'b0);
        run_period("ackcap", 2, 5, 1'b0, 1'b1);
        check("ackcap_lost", 32'(lost), 32'd0);

        // Illegal sequence: second rise while high.
        step(1'b0, 1'b0, 1'b1);
        check("ill_pre_cv", 32'(cap_valid), 32'd0);
        idle(3);
        step(1'b1, 1'b0, 1'b0);
        check("ill_err",   32'(err),       32'd1);
        check("ill_nocap", 32'(cap_valid), 32'd0);
        run_period("ill", 2, 7, 1'b0, 1'b0);
        check("ill_err_sticky", 32'(err), 32'd1);

        // Simultaneous edges while high: counting continues, no state change.
        step(1'b0, 1'b0, 1'b1);
        check("sim_pre_err", 32'(err),       32'd0);
        check("sim_pre_cv",  32'(cap_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        check("sim_err",   32'(err),              32'd1);
        check("sim_state", 32'(u_dut16.r_state), 32'd1);
        check("sim_nocap", 32'(cap_valid),        32'd0);
        idle(1);
        step(1'b0, 1'b1, 1'b0);
        idle(4);
        push_exp(4, 9);
        step(1'b1, 1'b0, 1'b0);
        pop_chk("sim");

        // Fall while low flags an error; then asynchronous reset in LOW.
        step(1'b0, 1'b0, 1'b1);
        check("low_pre_err", 32'(err), 32'd0);
        idle(1);
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        push_exp(3, 6);
        step(1'b1, 1'b0, 1'b0);
        pop_chk("low");
        idle(1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("low_neg_err", 32'(err),       32'd1);
        check("low_cv",      32'(cap_valid), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        nrst = 1'b1;
        idle(1);
        step(1'b1, 1'b0, 1'b0);
        check("rst_first_pos", 32'(cap_valid), 32'd0);
        run_period("rst", 4, 7, 1'b0, 1'b0);

        // Disable: edges ignored, results held, counter cleared.
        en = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("en_off_cv",    32'(cap_valid),      32'd1);
        check("en_off_ht",    32'(high_time),      32'd4);
        check("en_off_per",   32'(period),         32'd7);
        check("en_off_cnt",   32'(u_dut16.r_cnt),  32'd0);
        check("en_off_state", 32'(u_dut16.r_state), 32'd0);
        en = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        check("reen_first_per", 32'(period), 32'd7);
        run_period("reen", 2, 4, 1'b0, 1'b0);

        // Saturation on the 4-bit instance.
        nrst = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        idle(1);
        step(1'b1, 1'b0, 1'b0);
        idle(14);
        check("stall_early", 32'(stall4), 32'd0);
        idle(1);
        check("stall_set",   32'(stall4),          32'd1);
        check("stall_state", 32'(u_dut4.r_state),  32'd0);
        check("stall_cv",    32'(cap_valid4),      32'd0);
        step(1'b0, 1'b1, 1'b0);
        check("stall_neg_ign", 32'(err4),   32'd0);
        check("stall_hold",    32'(stall4), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check("stall_clr", 32'(stall4), 32'd0);
        check("stall16",   32'(stall),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_capture.md
PULSE_CAPTURE -- requirements
Module: pulse_capture

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the counter and the result fields.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port en, input, 1 bit: capture enable.
REQ-005 The block SHALL have port pos_edge, input, 1 bit: single-cycle qualified rising-edge pulse, synchronous to clk.
REQ-006 The block SHALL have port neg_edge, input, 1 bit: single-cycle qualified falling-edge pulse, synchronous to clk.
REQ-007 The block SHALL have port rd_ack, input, 1 bit: consumer acknowledge of the current result.
REQ-008 The block SHALL have port high_time, output, CNT_W bits: clk cycles from pos_edge to neg_edge.
REQ-009 The block SHALL have port period, output, CNT_W bits: clk cycles from pos_edge to the next pos_edge.
REQ-010 The block SHALL have port cap_valid, output, 1 bit: a result is held and has not yet been acknowledged.
REQ-011 The block SHALL have port lost, output, 1 bit: sticky flag; an unacknowledged result was overwritten.
REQ-012 The block SHALL have port err, output, 1 bit: sticky flag; an illegal edge sequence was seen.
REQ-013 The block SHALL have port stall, output, 1 bit: the counter saturated and the input is considered stuck.

Function
REQ-014 The FSM SHALL have three states: IDLE, HIGH and LOW.
REQ-015 The counter cnt SHALL be CNT_W bits wide and SHALL be loaded with 1 on an accepted pos_edge.
REQ-016 In HIGH and LOW, cnt SHALL increment by 1 every cycle and saturate at 2^CNT_W-1.
REQ-017 In IDLE, pos_edge -> load cnt, go to HIGH, clear stall.
REQ-018 In IDLE, neg_edge SHALL be ignored.
REQ-019 In HIGH, neg_edge -> latch internal high_lat<=cnt and go to LOW.
REQ-020 In HIGH, pos_edge without neg_edge SHALL set err, reload cnt, stay in HIGH, and produce no capture.
REQ-021 In LOW, pos_edge -> load period<=cnt and high_time<=high_lat, set cap_valid, reload cnt, and go to HIGH.
REQ-022 In LOW, neg_edge SHALL set err and otherwise be ignored.
REQ-023 Capture latency: period, high_time and cap_valid SHALL update on the clk edge that ends the pos_edge cycle.
REQ-024 pos_edge and neg_edge asserted in the same cycle SHALL set err, leave state and high_lat unchanged, and let cnt keep counting.
REQ-025 When cnt reaches 2^CNT_W-1 in HIGH or LOW, the FSM SHALL go to IDLE the next cycle and set stall.
REQ-026 stall SHALL stay set until the next accepted pos_edge.
REQ-027 cap_valid SHALL be cleared by rd_ack.
REQ-028 A capture and rd_ack in the same cycle SHALL leave cap_valid=1 with the new data, and lost SHALL NOT be set.
REQ-029 A capture while cap_valid=1 and rd_ack=0 SHALL overwrite period and high_time and set lost.
REQ-030 lost and err SHALL clear only on a cycle with rd_ack=1 and no new capture, or on reset.
REQ-031 en=0 SHALL synchronously force IDLE and cnt=0, ignore edges, and leave result registers, cap_valid and flags unchanged.
REQ-032 On re-enable, measurement SHALL restart from IDLE, so the first capture requires two pos_edges.
REQ-033 period and high_time SHALL be stable while cap_valid=1, except for an overwrite under REQ-029.

Reset
REQ-034 When nrst=0, the FSM SHALL be in IDLE, cnt=0, and high_lat=0.
REQ-035 When nrst=0, period, high_time, cap_valid, lost, err and stall SHALL all be 0.
REQ-036 Reset asserted mid-measurement SHALL discard the partial measurement with no capture.
REQ-037 After nrst rises, the first capture SHALL require two pos_edges.

Verification
REQ-038 Basic capture, CNT_W=16, en=1: pos_edge@c10, neg_edge@c13, pos_edge@c20 -> from c21 high_time=3, period=10, cap_valid=1.
REQ-039 Acknowledge and overwrite: rd_ack@c22 -> cap_valid=0 at c23; two more captures without rd_ack -> latest values held, lost=1.
REQ-040 Illegal sequence: pos_edge@c0, pos_edge@c5, neg_edge@c7, pos_edge@c12 -> err=1, high_time=2, period=7.
REQ-041 Simultaneous edges: in HIGH, pos_edge and neg_edge at the same cycle -> err=1, state stays HIGH, no capture.
REQ-042 Stall, CNT_W=4: pos_edge, then no edges for 16 cycles -> stall=1, FSM in IDLE, cap_valid=0; next pos_edge -> stall=0.
REQ-043 Reset mid-operation: nrst low during LOW state with cap_valid=1 -> all outputs 0 immediately (asynchronous); first capture only after two pos_edges post-release.
